// File: rtl/seg7_scan_display_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_display_if
//   Bus bundle between a digit source (the cascaded decimal counters and
//   their controller) and the multiplexed 7-segment driver.
//
//   Optional feature macro: SEG7_DP_EN adds the per-digit dp_mask signal.
//
//   Signals
//     bcd_in    4*DIGITS  packed BCD digits, [3:0] = digit 0 (least significant)
//     load      1         capture bcd_in (and dp_mask) into the driver's shadow
//     blank_en  1         suppress leading zeros
//     dp_mask   DIGITS    decimal-point enable per digit (SEG7_DP_EN only)
//     seg       7         {g,f,e,d,c,b,a}, registered by the driver
//     an        DIGITS    one-hot digit enable, registered by the driver
//     dp        1         decimal point, registered by the driver
//
//   Modports
//     master : digit source side (drives bcd_in/load/blank_en/dp_mask)
//     slave  : display driver side (drives seg/an/dp)
// ---------------------------------------------------------------------------
interface seg7_scan_display_if #(
  parameter int DIGITS = 4
);

  logic [4*DIGITS-1:0] bcd_in;
  logic                load;
  logic                blank_en;
`ifdef SEG7_DP_EN
  logic [DIGITS-1:0]   dp_mask;
`endif
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                dp;

`ifdef SEG7_DP_EN
  modport master (
    output bcd_in, load, blank_en, dp_mask,
    input  seg, an, dp
  );

  modport slave (
    input  bcd_in, load, blank_en, dp_mask,
    output seg, an, dp
  );
`else
  modport master (
    output bcd_in, load, blank_en,
    input  seg, an, dp
  );

  modport slave (
    input  bcd_in, load, blank_en,
    output seg, an, dp
  );
`endif

endinterface

// File: rtl/seg7_scan_display.sv
// ---------------------------------------------------------------------------
// seg7_scan_display
//   Multiplexed 7-segment driver. A full-width shadow copy of the packed BCD
//   digit bus is taken on load; a prescaler on the undivided system clock
//   steps a digit index every SCAN_DIV cycles, and the selected digit is
//   decoded onto a single registered segment bus with a one-hot anode enable.
//
//   Optional feature macro: SEG7_DP_EN
//     defined   : dp_mask is shadowed with bcd_in and drives dp per digit
//     undefined : no dp_mask, dp is held at the inactive level
//
//   Parameters
//     DIGITS          number of digits scanned (>= 2)
//     SCAN_DIV        system-clock cycles each digit stays lit (>= 2)
//     SEG_ACTIVE_LOW  1: seg/an/dp active-low (common anode), 0: active-high
//
//   Ports
//     clk    in   system clock, rising edge
//     reset  in   asynchronous, active-high reset
//     bus    slave modport of seg7_scan_display_if
//              in : bcd_in, load, blank_en, dp_mask (SEG7_DP_EN)
//              out: seg, an, dp (all registered)
// ---------------------------------------------------------------------------
module seg7_scan_display #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  seg7_scan_display_if.slave  bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // Inactive levels used for reset and for blanked segments.
  localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_OFF  = SEG_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic              DP_OFF  = SEG_ACTIVE_LOW;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // Active-high segment pattern {g,f,e,d,c,b,a}; values above 9 show a dash.
  function automatic logic [6:0] decode_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] seg_level(input logic [6:0] on);
    return SEG_ACTIVE_LOW ? ~on : on;
  endfunction

  function automatic logic [DIGITS-1:0] an_level(input logic [DIGITS-1:0] on);
    return SEG_ACTIVE_LOW ? ~on : on;
  endfunction

  function automatic logic dp_level(input logic on);
    return SEG_ACTIVE_LOW ? ~on : on;
  endfunction

  // -------------------------------------------------------------------------
  // Stage p0: prescaler, digit index and shadow register
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_p0;
  logic [IDX_W-1:0] idx_p0;
  logic [3:0]       shadow_p0 [DIGITS];
`ifdef SEG7_DP_EN
  logic [DIGITS-1:0] dp_shadow_p0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_p0 <= '0;
      idx_p0 <= '0;
    end else if (cnt_p0 == CNT_LAST) begin
      cnt_p0 <= '0;
      idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + IDX_W'(1);
    end else begin
      cnt_p0 <= cnt_p0 + CNT_W'(1);
    end
  end

  // Load is independent of the scan: a load on an index-advance edge simply
  // means the next digit is shown from the new value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DIGITS; k++) begin
        shadow_p0[k] <= '0;
      end
`ifdef SEG7_DP_EN
      dp_shadow_p0 <= '0;
`endif
    end else if (bus.load) begin
      for (int k = 0; k < DIGITS; k++) begin
        shadow_p0[k] <= bus.bcd_in[4*k +: 4];
      end
`ifdef SEG7_DP_EN
      dp_shadow_p0 <= bus.dp_mask;
`endif
    end
  end

  // Digit selection and leading-zero detection.
  // upper_zero[k] is set when shadow digits k..DIGITS-1 are all zero; it is
  // built by a running AND from the most significant digit downwards.
  logic [DIGITS-1:0] upper_zero;
  logic              run_zero;
  logic [3:0]        digit_sel;
  logic              zero_sel;
  logic              dp_sel;
  logic [DIGITS-1:0] an_on;
  logic              blank_sel;
  logic [6:0]        seg_on;

  always_comb begin
    upper_zero = '0;
    run_zero   = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run_zero      = run_zero & (shadow_p0[k] == 4'd0);
      upper_zero[k] = run_zero;
    end
  end

  always_comb begin
    digit_sel = '0;
    zero_sel  = 1'b0;
    dp_sel    = 1'b0;
    an_on     = '0;
    for (int k = 0; k < DIGITS; k++) begin
      an_on[k] = (idx_p0 == IDX_W'(k));
      if (idx_p0 == IDX_W'(k)) begin
        digit_sel = shadow_p0[k];
        zero_sel  = upper_zero[k];
`ifdef SEG7_DP_EN
        dp_sel    = dp_shadow_p0[k];
`endif
      end
    end
  end

  // Digit 0 is never blanked, so an all-zero value still shows a single '0'.
  assign blank_sel = bus.blank_en && zero_sel && (idx_p0 != '0);
  assign seg_on    = blank_sel ? 7'h00 : decode_digit(digit_sel);

  // -------------------------------------------------------------------------
  // Stage p1: registered display outputs
  // -------------------------------------------------------------------------
  logic [6:0]        seg_p1;
  logic [DIGITS-1:0] an_p1;
  logic              dp_p1;

  // The decimal point follows the mask even on a blanked digit, since the
  // anode stays enabled there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_p1 <= SEG_OFF;
      an_p1  <= AN_OFF;
      dp_p1  <= DP_OFF;
    end else begin
      seg_p1 <= seg_level(seg_on);
      an_p1  <= an_level(an_on);
`ifdef SEG7_DP_EN
      dp_p1  <= dp_level(dp_sel);
`else
      dp_p1  <= DP_OFF;
`endif
    end
  end

  assign bus.seg = seg_p1;
  assign bus.an  = an_p1;
  assign bus.dp  = dp_p1;

endmodule

// File: tb/tb_seg7_scan_display.sv
module tb_seg7_scan_display;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seg7_scan_display_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan_display #(
    .DIGITS         (DIGITS),
    .SCAN_DIV       (SCAN_DIV),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int         t;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  // Reference state: number of clock edges since reset release and the
  // value the display should currently be holding.
  int          t;
  logic [15:0] m_shadow;
  logic [3:0]  m_dp;

  int seg_tab [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                       'h7F, 'h6F, 'h40, 'h40, 'h40, 'h40, 'h40, 'h40};

  // Expected display after edge number n (n = 1 is the first edge after
  // reset release). Each digit is lit for SCAN_DIV edges in turn.
  function automatic exp_t model(input int n, input logic [15:0] sh,
                                 input logic [3:0] dpm, input logic blank);
    exp_t e;
    int   pos;
    int   digit;
    int   upper;
    pos   = ((n - 1) / SCAN_DIV) % DIGITS;
    digit = int'((sh >> (4 * pos)) & 16'h000F);
    upper = int'(sh >> (4 * pos));
    e.t   = n;
    if (blank && pos != 0 && upper == 0)
      e.seg = 7'h7F;
    else
      e.seg = 7'(~seg_tab[digit]);
    e.an = 4'(~(1 << pos));
`ifdef SEG7_DP_EN
    e.dp = ~dpm[pos];
`else
    e.dp = 1'b1;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input int tt, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%h expected=%h", name, tt, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_seg"}, -1, 32'(bus.seg), 32'h7F);
    chk({tag, "_an"},  -1, 32'(bus.an),  32'hF);
    chk({tag, "_dp"},  -1, 32'(bus.dp),  32'h1);
  endtask

  // Called at a falling edge: drives the inputs for the next rising edge and
  // records what that edge must produce.
  task automatic step(input logic ld, input logic [15:0] bcd, input logic blk,
                      input logic [3:0] dpm);
    bus.load     = ld;
    bus.bcd_in   = bcd;
    bus.blank_en = blk;
`ifdef SEG7_DP_EN
    bus.dp_mask  = dpm;
`endif
    t++;
    sb.push_back(model(t, m_shadow, m_dp, blk));
    if (ld) begin
      m_shadow = bcd;
      m_dp     = dpm;
    end
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset    = 1'b0;
    t        = 0;
    m_shadow = '0;
    m_dp     = '0;
  endtask

  // Monitor: the display presents a new registered value on every edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("seg", e.t, 32'(bus.seg), 32'(e.seg));
        chk("an",  e.t, 32'(bus.an),  32'(e.an));
        chk("dp",  e.t, 32'(bus.dp),  32'(e.dp));
      end
    end
  end

  initial begin : stimulus
    logic [15:0] r;
    reset        = 1'b1;
    bus.load     = 1'b0;
    bus.bcd_in   = '0;
    bus.blank_en = 1'b0;
`ifdef SEG7_DP_EN
    bus.dp_mask  = '0;
`endif
    t        = 0;
    m_shadow = '0;
    m_dp     = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset_hold");

    // Free-run on zeros; bcd_in wiggles without load and must be ignored.
    release_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 16'($urandom), 1'b0, 4'($urandom));

    // Asynchronous reset in the middle of a digit slot.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk_reset("async_reset");
    @(posedge clk);
    #1;
    chk_reset("reset_edge");
    release_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 16'h0000, 1'b0, 4'h0);

    // Plain digits, no blanking.
    step(1'b1, 16'h1234, 1'b0, 4'h0);
    for (int i = 0; i < 17; i++) step(1'b0, 16'($urandom), 1'b0, 4'h0);

    // Leading-zero blanking, then all zeros.
    step(1'b1, 16'h0050, 1'b1, 4'h0);
    for (int i = 0; i < 16; i++) step(1'b0, 16'h0000, 1'b1, 4'h0);
    step(1'b1, 16'h0000, 1'b1, 4'h0);
    for (int i = 0; i < 16; i++) step(1'b0, 16'hFFFF, 1'b1, 4'h0);

    // Out-of-range value shows a dash and counts as non-zero.
    step(1'b1, 16'h000A, 1'b1, 4'h0);
    for (int i = 0; i < 16; i++) step(1'b0, 16'h0000, 1'b1, 4'h0);
    step(1'b1, 16'h0A00, 1'b1, 4'h0);
    for (int i = 0; i < 16; i++) step(1'b0, 16'h0000, 1'b1, 4'h0);

    // Decimal point on digit 2 only, also while that digit is blanked.
    step(1'b1, 16'h0007, 1'b1, 4'b0100);
    for (int i = 0; i < 16; i++) step(1'b0, 16'h0000, 1'b1, 4'b1111);

    // Load held high: the display follows bcd_in; then it freezes.
    for (int i = 0; i < 24; i++) step(1'b1, 16'($urandom), 1'(i % 2), 4'($urandom));
    for (int i = 0; i < 24; i++) step(1'b0, 16'($urandom), 1'b1, 4'($urandom));

    // Randomized mix with values biased towards leading zeros.
    for (int i = 0; i < 400; i++) begin
      r = 16'($urandom);
      case ($urandom_range(0, 3))
        0: r = r & 16'h000F;
        1: r = r & 16'h00FF;
        2: r = r & 16'h0FFF;
        default: r = r;
      endcase
      step(($urandom_range(0, 3) == 0), r, 1'($urandom), 4'($urandom));
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_drain", t, 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
